// File: rtl/l1_mem_responder.sv
// -----------------------------------------------------------------------------
// l1_mem_responder
//
// Memory-side responder for the L1 cache line interface. Backs a storage array
// of 2**ADDR_W lines of 128 bits and answers each accepted read or write with
// a one-cycle mem_ready pulse LATENCY clock edges after acceptance. Acts as the
// slow main-memory model under the cache and as the template for the real
// memory controller front end.
//
// Parameters:
//   ADDR_W   low mem_addr bits used as the line index (upper bits alias)
//   LATENCY  edges from request acceptance to the mem_ready pulse (1..255)
//
// Ports:
//   clk         rising-edge clock
//   proc_reset  synchronous active-high reset
//   mem_read    line read request, held until mem_ready
//   mem_write   line write request, held until mem_ready (wins over read)
//   mem_addr    28-bit line address
//   mem_wdata   128-bit write line data
//   mem_rdata   128-bit read line data, valid while mem_ready=1 for a read
//   mem_ready   one-cycle completion pulse
//   rd_count    completed reads, saturating (MEM_STATS_EN, otherwise 0)
//   wr_count    completed writes, saturating (MEM_STATS_EN, otherwise 0)
//
// Build option:
//   MEM_STATS_EN  when defined, adds the saturating rd_count / wr_count
//                 completion counters; when undefined both outputs are 0.
// -----------------------------------------------------------------------------
module l1_mem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 4
) (
   input  logic         clk,
   input  logic         proc_reset,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready,
   output logic [15:0]  rd_count,
   output logic [15:0]  wr_count
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [127:0]        wdata_q, wdata_d;
   logic                we_q, we_d;
   logic                ready_q, ready_d;
   logic [127:0]        rdata_q, rdata_d;
   logic                commit;

   logic [127:0]        storage [2**ADDR_W];

   // Address bits above the index are deliberately ignored (aliasing).
   logic                unused_addr_hi;
   assign unused_addr_hi = ^mem_addr[27:ADDR_W];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               addr_d  = mem_addr[ADDR_W-1:0];
               wdata_d = mem_wdata;
               we_d    = mem_write;
               cnt_d   = CNT_INIT;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 8'd0) begin
               state_d = RESP;
               ready_d = 1'b1;
               commit  = 1'b1;
               if (!we_q) begin
                  rdata_d = storage[addr_q];
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         // Leaving RESP never accepts a request: one turnaround cycle for
         // the initiator to change its request.
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is never cleared; a write pending when reset hits is dropped.
   always_ff @(posedge clk) begin
      if (!proc_reset && commit && we_q) begin
         storage[addr_q] <= wdata_q;
      end
   end

   assign mem_rdata = rdata_q;
   assign mem_ready = ready_q;

`ifdef MEM_STATS_EN
   logic [15:0] rd_cnt_q;
   logic [15:0] wr_cnt_q;

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         rd_cnt_q <= 16'd0;
         wr_cnt_q <= 16'd0;
      end else if (commit) begin
         if (we_q) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
         end else begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
         end
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`else
   assign rd_count = 16'd0;
   assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_l1_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_l1_mem_responder
//
// Directed bench for l1_mem_responder (ADDR_W=10, LATENCY=4): a table of line
// transactions with hand-computed latency and read data, followed by
// hand-written sequences for writeback-then-refill turnaround, reset during a
// pending write and, when MEM_STATS_EN is defined, the saturating counters.
// -----------------------------------------------------------------------------
module tb_l1_mem_responder;

   localparam int ADDR_W = 10;
   localparam int LAT    = 4;

   localparam logic [127:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] DX = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;
   localparam logic [127:0] DY = 128'hFEDCBA98765432100011223344556677;
   localparam logic [127:0] DA = {16{8'hAA}};
   localparam logic [127:0] DZ = 128'h77777777888888889999999900000007;
   localparam logic [127:0] DW = 128'h11111111222222223333333344444444;
   localparam logic [127:0] DQ = 128'h40404040404040404040404040404040;

   logic         clk = 1'b0;
   logic         proc_reset;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic [15:0]  rd_count;
   logic [15:0]  wr_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   l1_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .rd_count   (rd_count),
      .wr_count   (wr_count)
   );

   typedef struct {
      logic         rd;
      logic         wr;
      logic [27:0]  addr;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Counts edges (starting with the next one) until mem_ready is seen high
   // just after an edge; 0 means it never came within the bound.
   task automatic wait_ready(output int n);
      bit found;
      n = 0;
      found = 1'b0;
      for (int i = 1; i <= 40 && !found; i++) begin
         @(posedge clk);
         #1;
         if (mem_ready) begin
            n = i;
            found = 1'b1;
         end
      end
   endtask

   // Drive one request from an idle point, hold it until mem_ready, check
   // latency and data, drop it, and check the pulse is one cycle wide.
   task automatic run_txn(input string name, input logic rd, input logic wr,
                          input logic [27:0] addr, input logic [127:0] wdata,
                          input logic [127:0] exp_rdata);
      int n;
      mem_read  = rd;
      mem_write = wr;
      mem_addr  = addr;
      mem_wdata = wdata;
      wait_ready(n);
      chk({name, "_lat"}, 128'(n), 128'(LAT + 1));
      chk({name, "_rdata"}, mem_rdata, exp_rdata);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(posedge clk);
      #1;
      chk({name, "_pulse"}, 128'(mem_ready), 128'd0);
   endtask

   initial begin
      int  n;
      bit  stayed_low;

      //             rd    wr    addr           wdata  exp_rdata
      vecs[0] = '{1'b0, 1'b1, 28'h0000012, D0,    128'd0};
      vecs[1] = '{1'b1, 1'b0, 28'h0000012, '0,    D0};
      vecs[2] = '{1'b0, 1'b1, 28'h0000401, DX,    D0};
      vecs[3] = '{1'b1, 1'b0, 28'h0000001, '0,    DX};
      vecs[4] = '{1'b1, 1'b1, 28'h0000005, DY,    DX};
      vecs[5] = '{1'b1, 1'b0, 28'h0000005, '0,    DY};
      vecs[6] = '{1'b0, 1'b1, 28'h0000080, DA,    DY};
      vecs[7] = '{1'b0, 1'b1, 28'h0000007, DZ,    DY};
      vecs[8] = '{1'b1, 1'b0, 28'hFFFFC80, '0,    DA};

      proc_reset = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 128'(mem_ready), 128'd0);
      chk("reset_rdata", mem_rdata, 128'd0);
      chk("reset_rd_count", 128'(rd_count), 128'd0);
      chk("reset_wr_count", 128'(wr_count), 128'd0);
      proc_reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp_rdata);
      end

      // Writeback then refill: refill presented during the RESP cycle must
      // wait one turnaround edge before acceptance.
      mem_write = 1'b1;
      mem_addr  = 28'h0000040;
      mem_wdata = DQ;
      wait_ready(n);
      chk("wb_lat", 128'(n), 128'(LAT + 1));
      mem_write = 1'b0;
      mem_read  = 1'b1;
      mem_addr  = 28'h0000080;
      wait_ready(n);
      chk("refill_lat", 128'(n), 128'(LAT + 2));
      chk("refill_rdata", mem_rdata, DA);
      mem_read = 1'b0;
      @(posedge clk);
      #1;
      chk("refill_pulse", 128'(mem_ready), 128'd0);
      run_txn("wb_readback", 1'b1, 1'b0, 28'h0000040, '0, DQ);

      // Reset while a write to line 7 is in BUSY: write is lost, no pulse.
      mem_write = 1'b1;
      mem_addr  = 28'h0000007;
      mem_wdata = DW;
      @(posedge clk);
      @(posedge clk);
      #1;
      proc_reset = 1'b1;
      mem_write  = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_busy_ready", 128'(mem_ready), 128'd0);
      chk("rst_busy_rdata", mem_rdata, 128'd0);
      proc_reset = 1'b0;
      stayed_low = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (mem_ready) stayed_low = 1'b0;
      end
      chk("rst_busy_no_pulse", 128'(stayed_low), 128'd1);
      run_txn("rst_busy_readback", 1'b1, 1'b0, 28'h0000007, '0, DZ);

`ifdef MEM_STATS_EN
      proc_reset = 1'b1;
      @(posedge clk);
      #1;
      proc_reset = 1'b0;
      chk("stats_clear_rd", 128'(rd_count), 128'd0);
      chk("stats_clear_wr", 128'(wr_count), 128'd0);
      run_txn("st_r0", 1'b1, 1'b0, 28'h0000012, '0, D0);
      run_txn("st_w0", 1'b0, 1'b1, 28'h0000100, DW, D0);
      run_txn("st_r1", 1'b1, 1'b0, 28'h0000100, '0, DW);
      run_txn("st_w1", 1'b0, 1'b1, 28'h0000101, DQ, DW);
      run_txn("st_r2", 1'b1, 1'b0, 28'h0000101, '0, DQ);
      chk("stats_rd_count", 128'(rd_count), 128'd3);
      chk("stats_wr_count", 128'(wr_count), 128'd2);
      force dut.rd_cnt_q = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.rd_cnt_q;
      run_txn("st_sat", 1'b1, 1'b0, 28'h0000012, '0, D0);
      chk("stats_rd_sat", 128'(rd_count), 128'h0FFFF);
      chk("stats_wr_after_sat", 128'(wr_count), 128'd2);
`else
      chk("nostats_rd_count", 128'(rd_count), 128'd0);
      chk("nostats_wr_count", 128'(wr_count), 128'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
